// File: rtl/e_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifter, valid/ready on both sides.
module e_alu_exec #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [3:0]               i_con_AluCtrl,
   input  logic                     i_con_Unsigned,
   input  logic [WIDTH-1:0]         i_A,
   input  logic [WIDTH-1:0]         i_B,
   input  logic [$clog2(WIDTH)-1:0] i_shamt,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [WIDTH-1:0]         o_result,
   output logic                     o_zero,
   output logic                     o_err
);

   localparam int unsigned SHW  = $clog2(WIDTH);
   localparam int unsigned CNTW = SHW + 1;
   localparam logic [CNTW-1:0] STEP = CNTW'(SHIFT_STEP);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [3:0]       op_q, op_nxt;
   logic [WIDTH-1:0] work_q, work_nxt;
   logic [CNTW-1:0]  rem_q, rem_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic             zero_nxt, err_nxt, valid_nxt;

   logic             accept;
   logic             is_shift;
   logic             lt;
   logic [WIDTH-1:0] imm_res;
   logic             imm_err;
   logic [CNTW-1:0]  step;
   logic [WIDTH-1:0] shifted;

   assign o_ready  = (state == IDLE) | ((state == DONE) & i_ready);
   assign accept   = i_valid & o_ready;
   assign is_shift = (i_con_AluCtrl == 4'd3) | (i_con_AluCtrl == 4'd4) | (i_con_AluCtrl == 4'd5);
   assign lt       = i_con_Unsigned ? (i_A < i_B) : ($signed(i_A) < $signed(i_B));

   // Single-cycle result for every code; shift codes here only cover shamt == 0
   always_comb begin
      imm_res = '0;
      imm_err = 1'b0;
      case (i_con_AluCtrl)
         4'd0:    imm_res = i_A & i_B;
         4'd1:    imm_res = i_A | i_B;
         4'd2:    imm_res = i_A + i_B;
         4'd3,
         4'd4,
         4'd5:    imm_res = i_B;
         4'd6:    imm_res = i_A - i_B;
         4'd7:    imm_res = WIDTH'(lt);
         4'd8:    imm_res = i_B << (WIDTH / 2);
         4'd9:    imm_res = i_A + WIDTH'(8);
         4'd12:   imm_res = ~(i_A | i_B);
         4'd13:   imm_res = i_A ^ i_B;
         default: imm_err = 1'b1;
      endcase
   end

   // One shifter step of min(SHIFT_STEP, remaining); sra keeps the captured sign in the msb
   always_comb begin
      step = (rem_q < STEP) ? rem_q : STEP;
      case (op_q)
         4'd3:    shifted = work_q << step;
         4'd4:    shifted = work_q >> step;
         default: shifted = $unsigned($signed(work_q) >>> step);
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      work_nxt  = work_q;
      rem_nxt   = rem_q;
      res_nxt   = o_result;
      zero_nxt  = o_zero;
      err_nxt   = o_err;
      valid_nxt = o_valid;
      case (state)
         IDLE: ;
         SHIFT: begin
            work_nxt = shifted;
            rem_nxt  = rem_q - step;
            if (rem_q == step) begin
               state_nxt = DONE;
               res_nxt   = shifted;
               zero_nxt  = (shifted == '0);
               err_nxt   = 1'b0;
               valid_nxt = 1'b1;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Accept overrides: from IDLE, or from DONE in the same cycle the result drains
      if (accept) begin
         op_nxt   = i_con_AluCtrl;
         work_nxt = i_B;
         rem_nxt  = CNTW'(i_shamt);
         if (is_shift && (i_shamt != '0)) begin
            state_nxt = SHIFT;
            valid_nxt = 1'b0;
         end else begin
            state_nxt = DONE;
            res_nxt   = imm_res;
            zero_nxt  = (imm_res == '0);
            err_nxt   = imm_err;
            valid_nxt = 1'b1;
         end
      end
   end

   // State and datapath registers; reset drops any in-flight op
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         op_q     <= '0;
         work_q   <= '0;
         rem_q    <= '0;
         o_result <= '0;
         o_zero   <= 1'b0;
         o_err    <= 1'b0;
         o_valid  <= 1'b0;
      end else begin
         state    <= state_nxt;
         op_q     <= op_nxt;
         work_q   <= work_nxt;
         rem_q    <= rem_nxt;
         o_result <= res_nxt;
         o_zero   <= zero_nxt;
         o_err    <= err_nxt;
         o_valid  <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_e_alu_exec.sv
// Randomized self-checking bench for e_alu_exec against a behavioural ALU model.
module tb_e_alu_exec;

   localparam int unsigned W    = 32;
   localparam int unsigned STEP = 1;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_valid;
   logic          o_ready;
   logic [3:0]    i_con_AluCtrl;
   logic          i_con_Unsigned;
   logic [W-1:0]  i_A;
   logic [W-1:0]  i_B;
   logic [4:0]    i_shamt;
   logic          o_valid;
   logic          i_ready;
   logic [W-1:0]  o_result;
   logic          o_zero;
   logic          o_err;

   int n_vec = 0;
   int n_err = 0;

   e_alu_exec #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_con_AluCtrl  (i_con_AluCtrl),
      .i_con_Unsigned (i_con_Unsigned),
      .i_A            (i_A),
      .i_B            (i_B),
      .i_shamt        (i_shamt),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_result       (o_result),
      .o_zero         (o_zero),
      .o_err          (o_err)
   );

   always #5 i_clk = ~i_clk;

   // Compare one observed value with its expected value
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference ALU: {err, result}
   function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic u,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
      logic [31:0] r;
      logic        e;
      r = '0;
      e = 1'b0;
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = b << sh;
         4'd4:  r = b >> sh;
         4'd5: begin
            r = b >> sh;
            if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
         end
         4'd6:  r = a - b;
         4'd7:  r = u ? 32'(a < b) : 32'((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
         4'd8:  r = b * 32'd65536;
         4'd9:  r = a + 32'd8;
         4'd12: r = ~(a | b);
         4'd13: r = a ^ b;
         default: e = 1'b1;
      endcase
      return {e, r};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Issue one op, check latency/busy/result, hold for 'hold' cycles of backpressure, then drain
   task automatic do_op(input logic [3:0] c, input logic u, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
      logic [32:0] exp;
      int          exp_lat;
      int          lat;
      int          t;
      exp     = ref_alu(c, u, a, b, sh);
      exp_lat = ((c == 4'd3 || c == 4'd4 || c == 4'd5) && sh != 0) ? (int'(sh) + STEP - 1) / STEP + 1 : 1;
      t = 0;
      while (!o_ready && t < 100) begin
         tick();
         t++;
      end
      chk("ready_before_op", 32'(o_ready), 32'd1);
      i_con_AluCtrl  = c;
      i_con_Unsigned = u;
      i_A            = a;
      i_B            = b;
      i_shamt        = sh;
      i_valid        = 1'b1;
      i_ready        = 1'b0;
      tick();
      i_valid        = 1'b0;
      i_con_AluCtrl  = 4'($urandom);
      i_con_Unsigned = 1'($urandom);
      i_A            = $urandom;
      i_B            = $urandom;
      i_shamt        = 5'($urandom);
      lat = 1;
      while (!o_valid && lat < 100) begin
         chk("busy_ready_low", 32'(o_ready), 32'd0);
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("valid", 32'(o_valid), 32'd1);
      chk("result", o_result, exp[31:0]);
      chk("zero", 32'(o_zero), 32'(exp[31:0] == 32'd0));
      chk("err", 32'(o_err), 32'(exp[32]));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", 32'(o_valid), 32'd1);
         chk("hold_result", o_result, exp[31:0]);
         chk("hold_ready_low", 32'(o_ready), 32'd0);
      end
      i_ready = 1'b1;
      #1;
      chk("drain_ready", 32'(o_ready), 32'd1);
      tick();
      i_ready = 1'b0;
      chk("drained_valid", 32'(o_valid), 32'd0);
   endtask

   initial begin
      logic seen;
      i_rst          = 1'b1;
      i_valid        = 1'b0;
      i_ready        = 1'b0;
      i_con_AluCtrl  = '0;
      i_con_Unsigned = 1'b0;
      i_A            = '0;
      i_B            = '0;
      i_shamt        = '0;
      repeat (2) tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_zero", 32'(o_zero), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      i_rst = 1'b0;
      tick();
      chk("rst_ready", 32'(o_ready), 32'd1);

      // Directed cases
      do_op(4'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
      do_op(4'd5, 1'b0, 32'd0, 32'h8000_0010, 5'd4, 0);
      do_op(4'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
      do_op(4'd7, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
      do_op(4'd13, 1'b0, 32'h0000_F0F0, 32'h0000_FFFF, 5'd0, 3);
      do_op(4'd3, 1'b0, 32'd0, 32'h0000_0001, 5'd31, 1);
      do_op(4'd4, 1'b0, 32'd0, 32'h8000_0000, 5'd0, 0);
      do_op(4'd9, 1'b0, 32'hFFFF_FFFC, 32'd0, 5'd0, 0);

      // Back-to-back with i_ready held high
      i_ready        = 1'b1;
      i_valid        = 1'b1;
      i_con_AluCtrl  = 4'd6;
      i_A            = 32'd5;
      i_B            = 32'd5;
      tick();
      chk("b2b_valid0", 32'(o_valid), 32'd1);
      chk("b2b_result0", o_result, 32'd0);
      chk("b2b_zero0", 32'(o_zero), 32'd1);
      chk("b2b_ready", 32'(o_ready), 32'd1);
      i_con_AluCtrl  = 4'd8;
      i_A            = $urandom;
      i_B            = 32'h0000_1234;
      tick();
      i_valid = 1'b0;
      chk("b2b_valid1", 32'(o_valid), 32'd1);
      chk("b2b_result1", o_result, 32'h1234_0000);
      chk("b2b_zero1", 32'(o_zero), 32'd0);
      tick();
      chk("b2b_drained", 32'(o_valid), 32'd0);
      i_ready = 1'b0;

      // Reset mid-shift
      i_con_AluCtrl = 4'd3;
      i_B           = 32'hDEAD_BEEF;
      i_shamt       = 5'd31;
      i_valid       = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (2) tick();
      i_rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_result", o_result, 32'd0);
      chk("midrst_zero", 32'(o_zero), 32'd0);
      chk("midrst_err", 32'(o_err), 32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      tick();
      i_rst = 1'b0;
      i_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_valid) seen = 1'b1;
      end
      chk("no_stale_result", 32'(seen), 32'd0);
      i_ready = 1'b0;
      do_op(4'd15, 1'b0, $urandom, $urandom, 5'($urandom), 0);
      do_op(4'd10, 1'b1, $urandom, $urandom, 5'($urandom), 1);

      // Random ops with random backpressure
      for (int n = 0; n < 150; n++) begin
         do_op(4'($urandom), 1'($urandom), $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
